// File: rtl/regfile_scoreboard_pkg.sv
// Shared register indices and types for the integer register file and its scoreboard.
package regfile_scoreboard_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam int unsigned NUM_REGS = 32;
  localparam reg_idx_t    REG_ZERO = 5'd0;
  localparam reg_idx_t    REG_SP   = 5'd2;
  localparam reg_idx_t    REG_A0   = 5'd10;
  localparam reg_idx_t    REG_A7   = 5'd17;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Writeback, decode read, issue and ECALL argument signals between the pipeline and the
// register file.
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  logic [63:0] wb_result;
  reg_idx_t    wb_rd;
  logic        wb_en_rd;
  logic        wb_is_bubble;
  reg_idx_t    rs1_addr;
  reg_idx_t    rs2_addr;
  logic        use_rs1;
  logic        use_rs2;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        hazard;
  logic        issue_valid;
  reg_idx_t    issue_rd;
  logic        issue_en_rd;
  logic        issue_ready;
  logic        flush;
  logic [63:0] a0, a1, a2, a3, a4, a5, a6, a7;

  // Pipeline side
  modport master (
    output wb_result, wb_rd, wb_en_rd, wb_is_bubble, rs1_addr, rs2_addr, use_rs1, use_rs2,
           issue_valid, issue_rd, issue_en_rd, flush,
    input  rs1_data, rs2_data, hazard, issue_ready, a0, a1, a2, a3, a4, a5, a6, a7
  );

  // Register file side
  modport slave (
    input  wb_result, wb_rd, wb_en_rd, wb_is_bubble, rs1_addr, rs2_addr, use_rs1, use_rs2,
           issue_valid, issue_rd, issue_en_rd, flush,
    output rs1_data, rs2_data, hazard, issue_ready, a0, a1, a2, a3, a4, a5, a6, a7
  );

endinterface

// File: rtl/regfile_scoreboard_reg_busy_tracker.sv
// Per-register count of in-flight writes: raises RAW hazards and back-pressures issue
// when a destination counter is saturated.
module reg_busy_tracker
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     issue_valid,
  input  reg_idx_t issue_rd,
  input  logic     issue_en_rd,
  input  logic     dec,
  input  reg_idx_t wb_rd,
  input  reg_idx_t rs1_addr,
  input  reg_idx_t rs2_addr,
  input  logic     use_rs1,
  input  logic     use_rs2,
  output logic     hazard,
  output logic     issue_ready
);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CntMax = '1;

  cnt_t cnt_q [NUM_REGS];
  cnt_t cnt_d [NUM_REGS];
  logic inc;
  logic pend1;
  logic pend2;

  // Hazard and issue back-pressure; a write landing this cycle frees its slot / operand
  always_comb begin
    issue_ready = !(issue_en_rd && issue_rd != REG_ZERO && cnt_q[issue_rd] == CntMax) ||
                  (dec && wb_rd == issue_rd);
    inc   = issue_valid && issue_en_rd && issue_rd != REG_ZERO && issue_ready && !flush;
    pend1 = rs1_addr != REG_ZERO && cnt_q[rs1_addr] != '0 &&
            !(cnt_q[rs1_addr] == cnt_t'(1) && dec && wb_rd == rs1_addr);
    pend2 = rs2_addr != REG_ZERO && cnt_q[rs2_addr] != '0 &&
            !(cnt_q[rs2_addr] == cnt_t'(1) && dec && wb_rd == rs2_addr);
    hazard = (use_rs1 && pend1) || (use_rs2 && pend2);
  end

  // Counter next state: flush clears everything, inc+dec on one register cancel
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush) begin
        cnt_d[r] = '0;
      end else if (inc && issue_rd == reg_idx_t'(r) && !(dec && wb_rd == reg_idx_t'(r))) begin
        cnt_d[r] = cnt_q[r] + cnt_t'(1);
      end else if (dec && wb_rd == reg_idx_t'(r) && !(inc && issue_rd == reg_idx_t'(r)) &&
                   cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - cnt_t'(1);
      end
    end
  end

  // Counter state register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A writeback with no matching in-flight issue means the pipeline lost track of a write
  dec_underflow: assert property (@(posedge clk) disable iff (reset)
    !(dec && cnt_q[wb_rd] == '0));

endmodule

// File: rtl/regfile_scoreboard.sv
// 32 x 64b integer register file with same-cycle writeback bypass, RAW scoreboard and
// committed a0..a7 taps for ECALL handling in WB.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter logic [63:0] STACK_INIT = 64'h0,
  parameter int unsigned CNT_W      = 2
) (
  input logic                  clk,
  input logic                  reset,
  regfile_scoreboard_if.slave  bus
);

  logic [63:0] regs_q [NUM_REGS];
  logic        wb_we;

  // Writeback qualifier; x0 writes are dropped
  always_comb begin
    wb_we = bus.wb_en_rd && !bus.wb_is_bubble && bus.wb_rd != REG_ZERO;
  end

  // Register array; x0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      regs_q[REG_SP] <= STACK_INIT;
    end else if (wb_we) begin
      regs_q[bus.wb_rd] <= bus.wb_result;
    end
  end

  // Read ports with WB bypass; a0..a7 deliberately see only committed state
  always_comb begin
    bus.rs1_data = (wb_we && bus.wb_rd == bus.rs1_addr) ? bus.wb_result : regs_q[bus.rs1_addr];
    bus.rs2_data = (wb_we && bus.wb_rd == bus.rs2_addr) ? bus.wb_result : regs_q[bus.rs2_addr];
    bus.a0 = regs_q[REG_A0];
    bus.a1 = regs_q[REG_A0 + 5'd1];
    bus.a2 = regs_q[REG_A0 + 5'd2];
    bus.a3 = regs_q[REG_A0 + 5'd3];
    bus.a4 = regs_q[REG_A0 + 5'd4];
    bus.a5 = regs_q[REG_A0 + 5'd5];
    bus.a6 = regs_q[REG_A0 + 5'd6];
    bus.a7 = regs_q[REG_A7];
  end

  reg_busy_tracker #(
    .CNT_W (CNT_W)
  ) u_busy (
    .clk         (clk),
    .reset       (reset),
    .flush       (bus.flush),
    .issue_valid (bus.issue_valid),
    .issue_rd    (bus.issue_rd),
    .issue_en_rd (bus.issue_en_rd),
    .dec         (wb_we),
    .wb_rd       (bus.wb_rd),
    .rs1_addr    (bus.rs1_addr),
    .rs2_addr    (bus.rs2_addr),
    .use_rs1     (bus.use_rs1),
    .use_rs2     (bus.use_rs2),
    .hazard      (bus.hazard),
    .issue_ready (bus.issue_ready)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, RAW hazard, saturation, flush,
// x0 handling and ECALL register timing.
module tb_regfile_scoreboard;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  regfile_scoreboard_if bus ();

  regfile_scoreboard #(
    .STACK_INIT (64'h8000),
    .CNT_W      (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.wb_result    = '0;
    bus.wb_rd        = '0;
    bus.wb_en_rd     = 1'b0;
    bus.wb_is_bubble = 1'b0;
    bus.rs1_addr     = '0;
    bus.rs2_addr     = '0;
    bus.use_rs1      = 1'b0;
    bus.use_rs2      = 1'b0;
    bus.issue_valid  = 1'b0;
    bus.issue_rd     = '0;
    bus.issue_en_rd  = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_en_rd = 1'b1;
    bus.issue_rd    = rd;
    tick();
  endtask

  task automatic wb(input logic [4:0] rd, input logic [63:0] val);
    idle();
    bus.wb_en_rd  = 1'b1;
    bus.wb_rd     = rd;
    bus.wb_result = val;
    tick();
  endtask

  task automatic test_reset();
    logic [63:0] av [8];
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    bus.rs1_addr = 5'd2;
    bus.rs2_addr = 5'd5;
    bus.use_rs1  = 1'b1;
    bus.use_rs2  = 1'b1;
    bus.issue_en_rd = 1'b1;
    bus.issue_rd    = 5'd7;
    #1;
    checks++;
    if (bus.rs1_data !== 64'h8000) begin
      errors++; $display("FAIL reset_sp got %h want %h", bus.rs1_data, 64'h8000);
    end
    checks++;
    if (bus.rs2_data !== 64'h0) begin
      errors++; $display("FAIL reset_x5 got %h want 0", bus.rs2_data);
    end
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++; $display("FAIL reset_hazard got %b want 0", bus.hazard);
    end
    checks++;
    if (bus.issue_ready !== 1'b1) begin
      errors++; $display("FAIL reset_issue_ready got %b want 1", bus.issue_ready);
    end
    av[0] = bus.a0; av[1] = bus.a1; av[2] = bus.a2; av[3] = bus.a3;
    av[4] = bus.a4; av[5] = bus.a5; av[6] = bus.a6; av[7] = bus.a7;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (av[i] !== 64'h0) begin
        errors++; $display("FAIL reset_a%0d got %h want 0", i, av[i]);
      end
    end
  endtask

  task automatic test_bypass();
    issue(5'd5);
    idle();
    bus.wb_en_rd  = 1'b1;
    bus.wb_rd     = 5'd5;
    bus.wb_result = 64'hDEAD;
    bus.rs1_addr  = 5'd5;
    bus.rs2_addr  = 5'd5;
    bus.use_rs1   = 1'b1;
    #1;
    checks++;
    if (bus.rs1_data !== 64'hDEAD) begin
      errors++; $display("FAIL bypass_rs1 got %h want %h", bus.rs1_data, 64'hDEAD);
    end
    checks++;
    if (bus.rs2_data !== 64'hDEAD) begin
      errors++; $display("FAIL bypass_rs2 got %h want %h", bus.rs2_data, 64'hDEAD);
    end
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++; $display("FAIL bypass_hazard got %b want 0", bus.hazard);
    end
    tick();
    idle();
    bus.rs1_addr = 5'd5;
    bus.use_rs1  = 1'b1;
    #1;
    checks++;
    if (bus.rs1_data !== 64'hDEAD) begin
      errors++; $display("FAIL array_x5 got %h want %h", bus.rs1_data, 64'hDEAD);
    end
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++; $display("FAIL array_x5_hazard got %b want 0", bus.hazard);
    end
    // Bubble suppresses the bypass and the write
    idle();
    bus.wb_en_rd     = 1'b1;
    bus.wb_is_bubble = 1'b1;
    bus.wb_rd        = 5'd5;
    bus.wb_result    = 64'hBAD;
    bus.rs1_addr     = 5'd5;
    #1;
    checks++;
    if (bus.rs1_data !== 64'hDEAD) begin
      errors++; $display("FAIL bubble_bypass got %h want %h", bus.rs1_data, 64'hDEAD);
    end
    tick();
  endtask

  task automatic test_raw();
    issue(5'd7);
    idle();
    bus.rs1_addr = 5'd7;
    bus.use_rs1  = 1'b1;
    #1;
    checks++;
    if (bus.hazard !== 1'b1) begin
      errors++; $display("FAIL raw_hazard got %b want 1", bus.hazard);
    end
    bus.wb_en_rd  = 1'b1;
    bus.wb_rd     = 5'd7;
    bus.wb_result = 64'h77;
    #1;
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++; $display("FAIL raw_resolved got %b want 0", bus.hazard);
    end
    checks++;
    if (bus.rs1_data !== 64'h77) begin
      errors++; $display("FAIL raw_bypass got %h want %h", bus.rs1_data, 64'h77);
    end
    tick();
    idle();
    bus.rs2_addr = 5'd7;
    bus.use_rs2  = 1'b1;
    #1;
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++; $display("FAIL raw_cleared got %b want 0", bus.hazard);
    end
  endtask

  task automatic test_saturate();
    issue(5'd7);
    issue(5'd7);
    issue(5'd7);
    // A 4th issue attempt while saturated must not be counted
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_en_rd = 1'b1;
    bus.issue_rd    = 5'd7;
    bus.rs1_addr    = 5'd7;
    bus.use_rs1     = 1'b1;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b0) begin
      errors++; $display("FAIL sat_ready got %b want 0", bus.issue_ready);
    end
    checks++;
    if (bus.hazard !== 1'b1) begin
      errors++; $display("FAIL sat_hazard got %b want 1", bus.hazard);
    end
    tick();
    wb(5'd7, 64'h1);
    idle();
    bus.rs1_addr    = 5'd7;
    bus.use_rs1     = 1'b1;
    bus.issue_en_rd = 1'b1;
    bus.issue_rd    = 5'd7;
    #1;
    checks++;
    if (bus.hazard !== 1'b1) begin
      errors++; $display("FAIL sat_after_wb_hazard got %b want 1", bus.hazard);
    end
    checks++;
    if (bus.issue_ready !== 1'b1) begin
      errors++; $display("FAIL sat_after_wb_ready got %b want 1", bus.issue_ready);
    end
  endtask

  task automatic test_sat_dec();
    // count[7] is 2 here; bring it to 3
    issue(5'd7);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_en_rd = 1'b1;
    bus.issue_rd    = 5'd7;
    bus.wb_en_rd    = 1'b1;
    bus.wb_rd       = 5'd7;
    bus.wb_result   = 64'h2;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b1) begin
      errors++; $display("FAIL satdec_ready got %b want 1", bus.issue_ready);
    end
    tick();
    idle();
    bus.issue_en_rd = 1'b1;
    bus.issue_rd    = 5'd7;
    #1;
    checks++;
    if (bus.issue_ready !== 1'b0) begin
      errors++; $display("FAIL satdec_still_full got %b want 0", bus.issue_ready);
    end
    wb(5'd7, 64'h3);
    wb(5'd7, 64'h4);
    idle();
    bus.rs1_addr = 5'd7;
    bus.use_rs1  = 1'b1;
    #1;
    checks++;
    if (bus.hazard !== 1'b1) begin
      errors++; $display("FAIL satdec_one_left got %b want 1", bus.hazard);
    end
    checks++;
    if (bus.rs1_data !== 64'h4) begin
      errors++; $display("FAIL satdec_x7 got %h want %h", bus.rs1_data, 64'h4);
    end
    wb(5'd7, 64'h5);
    idle();
    bus.rs1_addr = 5'd7;
    bus.use_rs1  = 1'b1;
    #1;
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++; $display("FAIL satdec_drained got %b want 0", bus.hazard);
    end
  endtask

  task automatic test_flush();
    issue(5'd9);
    issue(5'd9);
    idle();
    bus.flush       = 1'b1;
    bus.wb_en_rd    = 1'b1;
    bus.wb_rd       = 5'd9;
    bus.wb_result   = 64'h42;
    bus.issue_valid = 1'b1;
    bus.issue_en_rd = 1'b1;
    bus.issue_rd    = 5'd11;
    tick();
    idle();
    bus.rs1_addr = 5'd9;
    bus.use_rs1  = 1'b1;
    #1;
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++; $display("FAIL flush_x9_hazard got %b want 0", bus.hazard);
    end
    checks++;
    if (bus.rs1_data !== 64'h42) begin
      errors++; $display("FAIL flush_x9_data got %h want %h", bus.rs1_data, 64'h42);
    end
    idle();
    bus.rs2_addr = 5'd11;
    bus.use_rs2  = 1'b1;
    #1;
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++; $display("FAIL flush_issue_ignored got %b want 0", bus.hazard);
    end
  endtask

  task automatic test_x0_ecall();
    idle();
    bus.wb_en_rd  = 1'b1;
    bus.wb_rd     = 5'd0;
    bus.wb_result = 64'h1;
    bus.rs1_addr  = 5'd0;
    bus.use_rs1   = 1'b1;
    #1;
    checks++;
    if (bus.rs1_data !== 64'h0) begin
      errors++; $display("FAIL x0_bypass got %h want 0", bus.rs1_data);
    end
    tick();
    idle();
    bus.rs1_addr = 5'd0;
    bus.use_rs1  = 1'b1;
    #1;
    checks++;
    if (bus.rs1_data !== 64'h0) begin
      errors++; $display("FAIL x0_array got %h want 0", bus.rs1_data);
    end
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++; $display("FAIL x0_hazard got %b want 0", bus.hazard);
    end
    issue(5'd10);
    idle();
    bus.wb_en_rd  = 1'b1;
    bus.wb_rd     = 5'd10;
    bus.wb_result = 64'h5;
    #1;
    checks++;
    if (bus.a0 !== 64'h0) begin
      errors++; $display("FAIL a0_same_cycle got %h want 0", bus.a0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.a0 !== 64'h5) begin
      errors++; $display("FAIL a0_next_cycle got %h want %h", bus.a0, 64'h5);
    end
  endtask

  task automatic test_reset_mid();
    issue(5'd12);
    idle();
    reset           = 1'b1;
    bus.wb_en_rd    = 1'b1;
    bus.wb_rd       = 5'd12;
    bus.wb_result   = 64'h99;
    bus.issue_valid = 1'b1;
    bus.issue_en_rd = 1'b1;
    bus.issue_rd    = 5'd13;
    tick();
    reset = 1'b0;
    idle();
    bus.rs1_addr = 5'd12;
    bus.rs2_addr = 5'd13;
    bus.use_rs1  = 1'b1;
    bus.use_rs2  = 1'b1;
    #1;
    checks++;
    if (bus.rs1_data !== 64'h0) begin
      errors++; $display("FAIL rstmid_x12 got %h want 0", bus.rs1_data);
    end
    checks++;
    if (bus.hazard !== 1'b0) begin
      errors++; $display("FAIL rstmid_hazard got %b want 0", bus.hazard);
    end
    checks++;
    if (bus.a0 !== 64'h0) begin
      errors++; $display("FAIL rstmid_a0 got %h want 0", bus.a0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_bypass();
    test_raw();
    test_saturate();
    test_sat_dec();
    test_flush();
    test_x0_ecall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
